// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared MipsCPU control encodings (sequencer and datapath decoder)
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLR   = 3'd2,
    S_ACC   = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5
  } seq_state_e;

  localparam logic [2:0] ALU_ADD      = 3'b010;
  localparam logic       WB_IMM       = 1'b0;
  localparam logic       WB_ALU       = 1'b1;
  localparam int         REG_SUM      = 31;
  localparam int         MEM_SUM_ADDR = 0;

endpackage

// File: rtl/nim_sum_sequencer.sv
// rtl/nim_sum_sequencer.sv - loads NIM digits into r1..rN, sums them into r31, stores r31 to mem[0]
module nim_sum_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 10,
  parameter int DIGIT_W    = 4,
  parameter int DATA_W     = 32,
  parameter int RA_W       = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic                          busy,
  output logic                          done,
  output logic                          rf_we,
  output logic [RA_W-1:0]               rf_waddr,
  output logic [RA_W-1:0]               rf_raddr_a,
  output logic [RA_W-1:0]               rf_raddr_b,
  output logic [DATA_W-1:0]             imm,
  output logic                          wb_sel,
  output logic [2:0]                    alu_op,
  output logic                          mem_we,
  output logic [DATA_W-1:0]             mem_addr,
  output logic                          mem_wsel
);

  localparam logic [RA_W-1:0] LAST_IDX = RA_W'(NUM_DIGITS - 1);

  seq_state_e                    state_q, state_d;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits_q, digits_d;
  logic [RA_W-1:0]               idx_q, idx_d;
  logic [DIGIT_W-1:0]            cur_digit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      digits_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      idx_q    <= idx_d;
    end
  end

  // LOAD and ACC both walk idx 0..N-1 and leave it at 0 for the next phase
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    idx_d    = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          digits_d = digits;
          idx_d    = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_CLR;
        end else begin
          idx_d = idx_q + RA_W'(1);
        end
      end
      S_CLR:   state_d = S_ACC;
      S_ACC: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_STORE;
        end else begin
          idx_d = idx_q + RA_W'(1);
        end
      end
      S_STORE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == RA_W'(i)) cur_digit = digits_q[i*DIGIT_W +: DIGIT_W];
    end
  end

  // Decoded only from registered state/index, so start never reaches an output combinationally
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_raddr_a = '0;
    rf_raddr_b = '0;
    imm        = '0;
    wb_sel     = 1'b0;
    alu_op     = '0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wsel   = 1'b0;
    case (state_q)
      S_LOAD: begin
        busy     = 1'b1;
        rf_we    = 1'b1;
        rf_waddr = idx_q + RA_W'(1);
        wb_sel   = WB_IMM;
        imm      = DATA_W'(cur_digit);
      end
      S_CLR: begin
        busy     = 1'b1;
        rf_we    = 1'b1;
        rf_waddr = RA_W'(REG_SUM);
        wb_sel   = WB_IMM;
      end
      S_ACC: begin
        busy       = 1'b1;
        rf_we      = 1'b1;
        rf_waddr   = RA_W'(REG_SUM);
        rf_raddr_a = RA_W'(REG_SUM);
        rf_raddr_b = idx_q + RA_W'(1);
        alu_op     = ALU_ADD;
        wb_sel     = WB_ALU;
      end
      S_STORE: begin
        busy       = 1'b1;
        rf_raddr_b = RA_W'(REG_SUM);
        mem_we     = 1'b1;
        mem_addr   = DATA_W'(MEM_SUM_ADDR);
        mem_wsel   = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nim_sum_sequencer.sv
// tb/tb_nim_sum_sequencer.sv - scoreboard bench with a small MipsCPU datapath model behind the sequencer
module tb_nim_sum_sequencer;

  localparam int N  = 10;
  localparam int DW = 4;
  localparam logic [N*DW-1:0] BASIC = {4'd9, 4'd4, 4'd3, 4'd7, 4'd8, 4'd1, 4'd2, 4'd0, 4'd5, 4'd2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, start, start1;
  logic [N*DW-1:0] digits;
  logic [DW-1:0]   digits1;

  logic        busy, done, rf_we, wb_sel, mem_we, mem_wsel;
  logic [4:0]  rf_waddr, rf_raddr_a, rf_raddr_b;
  logic [31:0] imm, mem_addr;
  logic [2:0]  alu_op;

  logic        busy1, done1, rf_we1, wb_sel1, mem_we1, mem_wsel1;
  logic [4:0]  rf_waddr1, rf_raddr_a1, rf_raddr_b1;
  logic [31:0] imm1, mem_addr1;
  logic [2:0]  alu_op1;

  nim_sum_sequencer #(.NUM_DIGITS(N), .DIGIT_W(DW), .DATA_W(32), .RA_W(5)) u_dut (
    .clk(clk), .reset(reset), .start(start), .digits(digits), .busy(busy), .done(done),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .imm(imm), .wb_sel(wb_sel), .alu_op(alu_op), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wsel(mem_wsel)
  );

  nim_sum_sequencer #(.NUM_DIGITS(1), .DIGIT_W(DW), .DATA_W(32), .RA_W(5)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .digits(digits1), .busy(busy1), .done(done1),
    .rf_we(rf_we1), .rf_waddr(rf_waddr1), .rf_raddr_a(rf_raddr_a1), .rf_raddr_b(rf_raddr_b1),
    .imm(imm1), .wb_sel(wb_sel1), .alu_op(alu_op1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wsel(mem_wsel1)
  );

  // Single-cycle datapath models: combinational reads, writes land at the edge
  logic [31:0] rf [32];
  logic [31:0] mem [16];
  logic [31:0] rf1 [32];
  logic [31:0] mem1_0;
  logic [31:0] alu_y, alu_y1;

  always_comb alu_y  = (alu_op  == 3'b010) ? rf[rf_raddr_a]   + rf[rf_raddr_b]   : 32'hDEAD_BEEF;
  always_comb alu_y1 = (alu_op1 == 3'b010) ? rf1[rf_raddr_a1] + rf1[rf_raddr_b1] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= wb_sel ? alu_y : imm;
    if (mem_we && mem_addr < 32'd16) mem[mem_addr[3:0]] <= mem_wsel ? rf[rf_raddr_b] : 32'h0BAD_0BAD;
    if (rf_we1) rf1[rf_waddr1] <= wb_sel1 ? alu_y1 : imm1;
    if (mem_we1 && mem_addr1 == 32'd0) mem1_0 <= mem_wsel1 ? rf1[rf_raddr_b1] : 32'h0BAD_0BAD;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]     sum;
    logic [N*DW-1:0] digs;
    logic [31:0]     due;
  } exp_t;

  exp_t q[$];
  exp_t q1[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  function automatic logic [31:0] ref_sum(input logic [N*DW-1:0] d, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'((d >> (i*DW)) & 40'hF);
    return 32'(s);
  endfunction

  function automatic logic [31:0] digit_of(input logic [N*DW-1:0] d, input int i);
    return 32'((d >> (i*DW)) & 40'hF);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (!busy) begin
        chk("idle_strobes", {25'd0, rf_we, mem_we, mem_wsel, wb_sel, alu_op}, 32'd0);
        chk("idle_addr_imm", imm | mem_addr | {27'd0, rf_waddr | rf_raddr_a | rf_raddr_b}, 32'd0);
      end
      if (done) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: done pulse at cycle %0d, expected no sequence outstanding", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("mem0_sum", mem[0], e.sum);
          chk("r31_sum", rf[31], e.sum);
          for (int k = 0; k < N; k++) chk($sformatf("r%0d_digit", k + 1), rf[k+1], digit_of(e.digs, k));
        end
      end
      if (done1) begin
        if (q1.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done1: done pulse at cycle %0d, expected none", cyc);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("n1_done_cycle", cyc, e.due);
          chk("n1_mem0", mem1_0, e.sum);
          chk("n1_r31", rf1[31], e.sum);
          chk("n1_r1", rf1[1], digit_of(e.digs, 0));
        end
      end
    end
  end

  task automatic issue(input logic [N*DW-1:0] d);
    @(negedge clk);
    start  = 1'b1;
    digits = d;
    @(negedge clk);
    start  = 1'b0;
    q.push_back('{sum: ref_sum(d, N), digs: d, due: 32'(cyc + 2*N + 2)});
    digits = {$urandom, $urandom};
  endtask

  task automatic issue1(input logic [DW-1:0] d);
    @(negedge clk);
    start1  = 1'b1;
    digits1 = d;
    @(negedge clk);
    start1  = 1'b0;
    q1.push_back('{sum: 32'(d), digs: (N*DW)'(d), due: 32'(cyc + 4)});
    digits1 = DW'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || q1.size() != 0 || busy || busy1) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_total++;
      $display("FAIL timeout: sequence still outstanding after %0d cycles, expected done", t);
      q.delete();
      q1.delete();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start1 = 1'b0; digits = '0; digits1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    reset = 1'b0;

    issue(BASIC);
    wait_idle();
    chk("basic_mem0_41", mem[0], 32'd41);

    issue('0);
    wait_idle();
    chk("zero_mem0", mem[0], 32'd0);

    issue(BASIC);
    repeat (3) @(negedge clk);
    start = 1'b1; digits = {$urandom, $urandom};
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("busy_start_mem0_41", mem[0], 32'd41);

    issue(BASIC);
    repeat (13) @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("midrst_alu_op", {29'd0, alu_op}, 32'd0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    issue(BASIC);
    wait_idle();
    chk("after_rst_mem0_41", mem[0], 32'd41);

    for (int r = 0; r < 8; r++) begin
      issue({$urandom, $urandom});
      wait_idle();
    end

    begin
      logic [N*DW-1:0] d1, d2;
      d1 = {$urandom, $urandom};
      d2 = {$urandom, $urandom};
      @(negedge clk);
      start = 1'b1; digits = d1;
      @(negedge clk);
      q.push_back('{sum: ref_sum(d1, N), digs: d1, due: 32'(cyc + 2*N + 2)});
      q.push_back('{sum: ref_sum(d2, N), digs: d2, due: 32'(cyc + 4*N + 6)});
      repeat (2*N + 2) @(negedge clk);
      digits = d2;
      repeat (2) @(negedge clk);
      start = 1'b0;
      digits = '0;
      wait_idle();
    end

    issue1(4'd7);
    wait_idle();
    chk("n1_mem0_7", mem1_0, 32'd7);
    issue1(DW'($urandom));
    wait_idle();

    repeat (5) @(negedge clk);
    chk("queues_drained", 32'(q.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nim_sum_sequencer.md
Name: nim_sum_sequencer

Overview:
Control sequencer that sits directly upstream of the MipsCPU datapath and drives its register-file, ALU and data-memory control inputs.
- On a start pulse it writes each NIM digit as an immediate into registers 1..NUM_DIGITS.
- It then accumulates them into register 31 through the ALU, and stores the sum to data memory address 0.
- It replaces the hand-applied control stimulus used so far and gives the bench a done flag in place of a fixed delay.

Parameters:
NUM_DIGITS, 10, number of NIM digits; legal range 1..30 (registers 1..30).
DIGIT_W, 4, width of one digit.
DATA_W, 32, datapath word width.
RA_W, 5, register-file address width.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; accepted only in IDLE
digits  in  NUM_DIGITS*DIGIT_W  packed digits, digit 0 in LSBs; sampled when start is accepted
busy  out  1  high from first LOAD cycle through STORE
done  out  1  one-cycle pulse in DONE state
rf_we  out  1  register-file write enable
rf_waddr  out  RA_W  register-file write address
rf_raddr_a  out  RA_W  register-file read port A address
rf_raddr_b  out  RA_W  register-file read port B address
imm  out  DATA_W  immediate value, zero-extended digit
wb_sel  out  1  0 = write back imm, 1 = write back ALU result
alu_op  out  3  ALU operation; ADD = 3'b010, all other values unused
mem_we  out  1  data-memory write enable
mem_addr  out  DATA_W  data-memory address
mem_wsel  out  1  1 = memory write data comes from read port B

Behaviour:
- Reset (synchronous, active-high): state = IDLE, digit snapshot cleared, index = 0. All outputs are 0, including every address and imm. The block never clears register-file or memory contents.
- Reset asserted mid-sequence: on the next edge the FSM enters IDLE and drops all strobes. A partial write sequence is abandoned.
- FSM states: IDLE, LOAD, CLR, ACC, STORE, DONE.
- IDLE:
  - start = 1 latches digits into an internal snapshot, sets index k = 0, goes to LOAD.
  - Digit changes after acceptance have no effect.
- LOAD, NUM_DIGITS cycles, k = 0..N-1:
  - rf_we = 1, rf_waddr = k+1, wb_sel = 0, imm = zero-extended digit k.
  - After k = N-1, go to CLR.
- CLR, 1 cycle: rf_we = 1, rf_waddr = 31, wb_sel = 0, imm = 0.
- ACC, NUM_DIGITS cycles, k = 0..N-1:
  - rf_raddr_a = 31, rf_raddr_b = k+1, alu_op = ADD, wb_sel = 1, rf_we = 1, rf_waddr = 31.
  - This relies on the single-cycle datapath: each write lands at the edge, so the next cycle reads the updated r31.
- STORE, 1 cycle: rf_raddr_b = 31, mem_we = 1, mem_addr = 0, mem_wsel = 1, rf_we = 0.
- DONE, 1 cycle: done = 1, then return to IDLE.
- In every cycle, outputs not listed for the current state are 0.
- Latency: start accepted at edge E0; done is high in cycle 2N+3 after E0 (N=10 gives 23); busy spans 2N+2 cycles.
- start while busy or in DONE: ignored, not queued.
- start asserted continuously: a new sequence begins in the first IDLE cycle after DONE.
- Digit values above 9 are not checked; they are passed through zero-extended.
- Arithmetic width: max sum 30*15 = 450 fits in DATA_W; no overflow handling.
- Outputs are registered from state/index, so there is no combinational path from start to any control output.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enum;
  - ALU_ADD = 3'b010;
  - WB_IMM / WB_ALU;
  - REG_SUM = 31;
  - MEM_SUM_ADDR = 0.
- The package is reused by the datapath control decoder.
- No sub-module is needed; an index counter and the FSM in one module suffice.

Test Plan:
- Basic sum: reset, digits 2,5,0,2,1,8,7,3,4,9, pulse start → done at cycle 23; r1..r10 = digits; r31 = 41; DataMemory[0] = 41.
- All-zero digits → r31 = 0, DataMemory[0] = 0, done at cycle 23.
- Start while busy: second start at cycle 5 with different digits → ignored; result 41, single done pulse.
- Digits changed after acceptance (all set to 9 in cycle 2) → result still 41.
- Reset in cycle 14 (mid-ACC) → next cycle IDLE with all strobes 0 and no done pulse; a following start completes normally with 41.
- NUM_DIGITS = 1, digit 7 → done at cycle 5; r1 = 7; r31 = 7; DataMemory[0] = 7.
